// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU: owns pc, IR, zf
// and the ALU result register, and steers the external ALU, register file and memories.
module cpu_seq #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [1:0]  rf_ra,
    output logic [1:0]  rf_rb,
    output logic        rf_we,
    output logic [1:0]  rf_wa,
    output logic        rf_wsel,
    output logic [3:0]  alu_op,
    output logic        alu_in0_sel,
    output logic        alu_in1_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_zf,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    input  logic        dmem_ack,
    output logic [7:0]  pc,
    output logic        zf,
    output logic        halted
);
    localparam logic [3:0] OP_AND   = 4'h0, OP_OR    = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
                           OP_CMP   = 4'h4, OP_ADDI  = 4'h5, OP_SUBI = 4'h6, OP_CMPI = 4'h7,
                           OP_LOAD  = 4'h8, OP_STORE = 4'h9, OP_LI   = 4'hA, OP_JMP  = 4'hB,
                           OP_JNZ   = 4'hC, OP_JMPR  = 4'hD;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state, state_nx;
    logic [15:0] ir;
    logic [7:0]  res;
    logic [7:0]  pc_nx;

    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    assign op  = ir[15:12];
    assign rd  = ir[11:10];
    assign rs  = ir[9:8];
    assign imm = ir[7:0];

    // Opcode classes follow the encoding order: register ops first, then the zf writers.
    logic is_reg_op, writes_zf, legal, is_mem, no_wb;
    assign is_reg_op = (op <= OP_CMP);
    assign writes_zf = (op <= OP_CMPI);
    assign legal     = (op <= OP_JMPR);
    assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    assign no_wb     = op inside {OP_JMP, OP_JNZ, OP_JMPR, OP_CMP, OP_CMPI};

    assign imem_addr = pc;
    assign dmem_addr = res;

    // JNZ looks at zf as it stood before this instruction.
    always_comb begin
        pc_nx = pc + 8'd1;
        case (op)
            OP_JMP:  pc_nx = imm;
            OP_JMPR: pc_nx = pc + imm;
            OP_JNZ:  if (!zf) pc_nx = imm;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ir    <= '0;
            pc    <= RESET_PC;
            zf    <= 1'b0;
            res   <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && imem_ack) ir <= imem_rdata;
            if (state == EXEC) begin
                res <= alu_out;
                pc  <= pc_nx;
                if (writes_zf) zf <= alu_zf;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        rf_ra       = '0;
        rf_rb       = '0;
        rf_we       = 1'b0;
        rf_wa       = '0;
        rf_wsel     = 1'b0;
        alu_op      = '0;
        alu_in0_sel = 1'b0;
        alu_in1_sel = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE:  state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = DECODE;
            end
            DECODE: begin
                rf_ra    = rs;
                rf_rb    = rd;
                state_nx = legal ? EXEC : HALT;
            end
            EXEC: begin
                rf_ra       = rs;
                rf_rb       = rd;
                alu_op      = op;
                alu_in0_sel = !is_reg_op;
                alu_in1_sel = (op == OP_JMPR);
                if (is_mem)     state_nx = MEM;
                else if (no_wb) state_nx = FETCH;
                else            state_nx = WB;
            end
            MEM: begin
                rf_ra    = rs;
                rf_rb    = rd;
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STORE);
                if (dmem_ack) state_nx = (op == OP_LOAD) ? WB : FETCH;
            end
            WB: begin
                rf_ra    = rs;
                rf_rb    = rd;
                rf_we    = 1'b1;
                rf_wa    = rd;
                rf_wsel  = (op == OP_LOAD);
                state_nx = FETCH;
            end
            HALT:    halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: models imem/dmem, register file and ALU around the
// sequencer and scoreboards register writes and data-memory accesses.
module tb_cpu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [1:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we, rf_wsel;
    logic [3:0]  alu_op;
    logic        alu_in0_sel, alu_in1_sel;
    logic [7:0]  alu_out;
    logic        alu_zf;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr, dmem_rdata;
    logic [7:0]  pc;
    logic        zf, halted;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_pc;

    cpu_seq #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wsel(rf_wsel),
        .alu_op(alu_op), .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel),
        .alu_out(alu_out), .alu_zf(alu_zf),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .pc(pc), .zf(zf), .halted(halted)
    );

    always #5 clk = ~clk;

    // Surrounding datapath: register file, operand muxes and ALU.
    logic [7:0] rf [4];
    logic [7:0] in0, in1, wdata;
    assign wdata = rf_wsel ? dmem_rdata : dmem_addr;
    always @(posedge clk) if (rf_we) rf[rf_wa] <= wdata;

    always_comb begin
        in0     = alu_in0_sel ? imem_rdata[7:0] : rf[rf_ra];
        in1     = alu_in1_sel ? pc : rf[rf_rb];
        alu_out = 8'h00;
        case (alu_op)
            4'h0:                      alu_out = in0 & in1;
            4'h1:                      alu_out = in0 | in1;
            4'h3, 4'h6:                alu_out = in1 - in0;
            4'h4, 4'h7:                alu_out = (in0 == in1) ? 8'h01 : 8'h00;
            4'hA, 4'hB, 4'hC:          alu_out = in0;
            4'h2, 4'h5, 4'h8, 4'h9, 4'hD: alu_out = in0 + in1;
            default:                   alu_out = 8'h00;
        endcase
        alu_zf = (alu_out == 8'h00);
    end

    typedef struct { logic [1:0] wa; logic wsel; logic [7:0] data; } wr_t;
    typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } mem_t;
    wr_t  wr_q[$];
    mem_t mem_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_wr();
        wr_t e;
        chk("wr_expected", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
            e = wr_q.pop_front();
            chk("wr_addr", rf_wa, e.wa);
            chk("wr_sel", rf_wsel, e.wsel);
            chk("wr_data", wdata, e.data);
        end
    endtask

    task automatic check_mem();
        mem_t e;
        chk("mem_expected", 32'(mem_q.size() > 0), 1);
        if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            chk("mem_we", dmem_we, e.we);
            chk("mem_addr", dmem_addr, e.addr);
            if (e.we) chk("mem_sdata", rf[rf_rb], e.data);
        end
    endtask

    // Serves one instruction from its fetch until the next fetch (or halt).
    task automatic exec_instr(input logic [15:0] ins, input int fwait, input int mwait,
                              input logic [7:0] ldata, output int ncyc, output int nwe, output int nmem);
        int t, w;
        bit done;
        ncyc = 0; nwe = 0; nmem = 0; w = 0; t = 0; done = 0;
        while (!imem_req && t < 20) begin @(negedge clk); t++; end
        chk("fetch_seen", imem_req, 1);
        if (!imem_req) return;
        chk("imem_addr", imem_addr, exp_pc);
        repeat (fwait) begin
            ncyc++;
            @(negedge clk);
            chk("fetch_hold", {imem_req, imem_addr}, {1'b1, exp_pc});
        end
        imem_ack = 1'b1; imem_rdata = ins; ncyc++;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            dmem_ack = 1'b0;
            if (imem_req || halted) done = 1;
            else begin
                ncyc++;
                if (rf_we) begin nwe++; check_wr(); end
                if (dmem_req) begin
                    if (nmem == 0) check_mem();
                    nmem++;
                    if (w == mwait) begin dmem_ack = 1'b1; dmem_rdata = ldata; end
                    else w++;
                end
                @(negedge clk);
            end
        end
        chk("instr_done", 32'(done), 1);
    endtask

    task automatic run(input string tag, input logic [15:0] ins, input int fw, input int mw,
                       input logic [7:0] ld, input int ecyc, input int ewe, input int emem,
                       input logic [7:0] npc);
        int c, nw, nm;
        exec_instr(ins, fw, mw, ld, c, nw, nm);
        chk({tag, "_cycles"}, c, ecyc);
        chk({tag, "_rf_we"}, nw, ewe);
        chk({tag, "_dmem_cycles"}, nm, emem);
        chk({tag, "_pc"}, pc, npc);
        exp_pc = npc;
    endtask

    function automatic wr_t w(input logic [1:0] a, input logic s, input logic [7:0] d);
        wr_t r; r.wa = a; r.wsel = s; r.data = d; return r;
    endfunction

    function automatic mem_t m(input logic we, input logic [7:0] a, input logic [7:0] d);
        mem_t r; r.we = we; r.addr = a; r.data = d; return r;
    endfunction

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = 16'h0000; dmem_rdata = 8'h00; exp_pc = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_zf", zf, 0);
        chk("rst_halted", halted, 0);
        chk("rst_reqs", {imem_req, dmem_req, dmem_we, rf_we}, 4'b0000);
        chk("rst_dmem_addr", dmem_addr, 8'h00);
        rst_n = 1'b1;
        #1 chk("idle_no_req", imem_req, 0);
        @(negedge clk);
        chk("first_req", {imem_req, imem_addr}, {1'b1, 8'h00});
        repeat (2) @(negedge clk);
        chk("stall_req_held", imem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_drop_req", imem_req, 0);
        chk("async_pc", pc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        wr_q.push_back(w(2'd1, 1'b0, 8'h05)); run("li_r1",   16'hA405, 0, 0, 8'h00, 4, 1, 0, 8'h01);
        wr_q.push_back(w(2'd2, 1'b0, 8'h05)); run("li_r2",   16'hA805, 0, 0, 8'h00, 4, 1, 0, 8'h02);
        wr_q.push_back(w(2'd1, 1'b0, 8'h00)); run("sub",     16'h3600, 0, 0, 8'h00, 4, 1, 0, 8'h03);
        chk("sub_zf", zf, 1);
        wr_q.push_back(w(2'd1, 1'b0, 8'h03)); run("addi",    16'h5403, 2, 0, 8'h00, 6, 1, 0, 8'h04);
        chk("addi_zf", zf, 0);
        wr_q.push_back(w(2'd0, 1'b0, 8'h07)); run("li_r0",   16'hA007, 0, 0, 8'h00, 4, 1, 0, 8'h05);
        wr_q.push_back(w(2'd3, 1'b0, 8'h07)); run("li_r3",   16'hAC07, 0, 0, 8'h00, 4, 1, 0, 8'h06);
        run("cmp_eq", 16'h4C00, 0, 0, 8'h00, 3, 0, 0, 8'h07);
        chk("cmp_eq_zf", zf, 0);
        run("jnz_taken", 16'hC040, 0, 0, 8'h00, 3, 0, 0, 8'h40);
        wr_q.push_back(w(2'd3, 1'b0, 8'h09)); run("li_r3b",  16'hAC09, 0, 0, 8'h00, 4, 1, 0, 8'h41);
        run("cmp_ne", 16'h4C00, 0, 0, 8'h00, 3, 0, 0, 8'h42);
        chk("cmp_ne_zf", zf, 1);
        run("jnz_not", 16'hC080, 0, 0, 8'h00, 3, 0, 0, 8'h43);
        wr_q.push_back(w(2'd2, 1'b0, 8'h20)); run("li_r2b",  16'hA820, 0, 0, 8'h00, 4, 1, 0, 8'h44);
        mem_q.push_back(m(1'b0, 8'h30, 8'h00));
        wr_q.push_back(w(2'd2, 1'b1, 8'hA5)); run("load",    16'h8810, 0, 3, 8'hA5, 8, 1, 4, 8'h45);
        mem_q.push_back(m(1'b1, 8'h08, 8'h03));
        run("store", 16'h9405, 0, 0, 8'h00, 4, 0, 1, 8'h46);
        run("jmp_fe",  16'hB0FE, 0, 0, 8'h00, 3, 0, 0, 8'hFE);
        run("jmpr_wrap", 16'hD005, 0, 0, 8'h00, 3, 0, 0, 8'h03);
        run("jmp_ff",  16'hB0FF, 0, 0, 8'h00, 3, 0, 0, 8'hFF);
        wr_q.push_back(w(2'd0, 1'b0, 8'h01)); run("li_wrap", 16'hA001, 0, 0, 8'h00, 4, 1, 0, 8'h00);
        chk("zf_kept", zf, 1);
        run("illegal", 16'hF000, 0, 0, 8'h00, 2, 0, 0, 8'h00);
        chk("halted", halted, 1);
        repeat (3) begin
            imem_ack = 1'b1; imem_rdata = 16'hA4FF;
            @(negedge clk);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        chk("halt_pc_frozen", pc, 8'h00);
        chk("halt_no_req", {imem_req, dmem_req, rf_we}, 3'b000);
        chk("halt_sticky", halted, 1);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        #2 rst_n = 1'b0;
        #1 chk("reset_clears_halt", halted, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
